// File: rtl/ped_signal_ctrl_pkg.sv
// Shared definitions for the pedestrian signal controller: FSM states,
// the one-hot lamp codes used by the upstream traffic_light controller,
// and a legality check for the lamp bus.
package ped_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_FLASH = 2'd2,
        ST_FAULT = 2'd3
    } ped_state_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    // Exactly one lamp lit is the only legal encoding.
    function automatic logic is_legal_light(input logic [2:0] light);
        return (light == LIGHT_RED) || (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
    endfunction

endpackage

// File: rtl/ped_signal_ctrl_phase_timer.sv
// Phase timer: loadable down-counter that parks at zero, plus the blink
// divider used during the flashing clearance phase.
module ped_phase_timer #(
    parameter int CNT_W      = 8,
    parameter int FLASH_HALF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    input  logic             blink_run,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             blink
);

    localparam int BW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(FLASH_HALF - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             blink_q, blink_d;

    // Timer registers; blink idles high so the lamp is steady outside FLASH.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b1;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            count_q <= count_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    // Countdown: clear beats load, otherwise decrement and stop at zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Blink divider: toggles every FLASH_HALF cycles while running, else re-arms high.
    always_comb begin
        blink_d = 1'b1;
        bcnt_d  = '0;
        if (blink_run) begin
            blink_d = blink_q;
            if (bcnt_q == HALF_LAST) begin
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
    assign blink = blink_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller. Latches button requests and grants a
// WALK then blinking FLASH phase at the start of a red interval; reports
// red intervals cut short (abort) and illegal lamp encodings (sticky fault).
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int WALK_TIME  = 12,
    parameter int FLASH_TIME = 6,
    parameter int FLASH_HALF = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             blink,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             abort,
    output logic             fault
);

    ped_state_e       state_q, state_d;
    logic [2:0]       light_q, light_d;
    logic             btn_q, btn_d;
    logic             req_q, req_d;
    logic             abort_q, abort_d;

    logic             btn_rise, red_now, red_entry, illegal;
    logic             tmr_load, tmr_clear, tmr_zero, tmr_blink_run, tmr_blink;
    logic [CNT_W-1:0] tmr_load_val, tmr_count;

    assign btn_rise  = btn & ~btn_q;
    assign red_now   = (light == LIGHT_RED);
    assign red_entry = red_now && (light_q != LIGHT_RED);
    assign illegal   = !is_legal_light(light);

    // State register; light_q resets to red so the red current at reset is not an entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            light_q <= LIGHT_RED;
            btn_q   <= 1'b0;
            req_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            light_q <= light_d;
            btn_q   <= btn_d;
            req_q   <= req_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic, priority: illegal light > early red end > normal phase flow.
    always_comb begin
        // NOTE: every output of this block is defaulted up front so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        light_d      = light;
        btn_d        = btn;
        req_d        = req_q;
        abort_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_clear    = 1'b0;

        if (illegal) begin
            state_d   = ST_FAULT;
            tmr_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (btn_rise) req_d = 1'b1;
                    if (red_entry && (req_q || btn_rise)) begin
                        state_d      = ST_WALK;
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(WALK_TIME - 1);
                        req_d        = 1'b0;
                    end
                end
                ST_WALK: begin
                    if (!red_now) begin
                        state_d   = ST_IDLE;
                        abort_d   = 1'b1;
                        tmr_clear = 1'b1;
                        req_d     = 1'b1;
                    end else if (tmr_zero) begin
                        state_d      = ST_FLASH;
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(FLASH_TIME - 1);
                    end
                end
                ST_FLASH: begin
                    if (btn_rise) req_d = 1'b1;
                    if (!red_now) begin
                        state_d   = ST_IDLE;
                        abort_d   = 1'b1;
                        tmr_clear = 1'b1;
                        req_d     = 1'b1;
                    end else if (tmr_zero) begin
                        state_d   = ST_IDLE;
                        tmr_clear = 1'b1;
                    end
                end
                ST_FAULT: begin
                    tmr_clear = 1'b1;
                end
                default: begin
                    state_d   = ST_FAULT;
                    tmr_clear = 1'b1;
                end
            endcase
        end

        tmr_blink_run = (state_q == ST_FLASH) && (state_d == ST_FLASH);
    end

    // Output decode from registered state only.
    always_comb begin
        walk        = (state_q == ST_WALK);
        dont_walk   = (state_q != ST_WALK);
        fault       = (state_q == ST_FAULT);
        blink       = tmr_blink;
        countdown   = tmr_count;
        req_pending = req_q;
        abort       = abort_q;
    end

    ped_phase_timer #(
        .CNT_W      (CNT_W),
        .FLASH_HALF (FLASH_HALF)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .clear     (tmr_clear),
        .blink_run (tmr_blink_run),
        .count     (tmr_count),
        .zero      (tmr_zero),
        .blink     (tmr_blink)
    );

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl. Outputs are compared as one packed
// word {walk, dont_walk, blink, req_pending, abort, fault, countdown}.
module tb_ped_signal_ctrl;
    import ped_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       light;
    logic             btn;
    logic             walk, dont_walk, blink, req_pending, abort, fault;
    logic [CNT_W-1:0] countdown;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ped_signal_ctrl #(
        .WALK_TIME  (12),
        .FLASH_TIME (6),
        .FLASH_HALF (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light       (light),
        .btn         (btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .blink       (blink),
        .countdown   (countdown),
        .req_pending (req_pending),
        .abort       (abort),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pack(input logic w, input logic dw, input logic bl,
                                         input logic rq, input logic ab, input logic ft,
                                         input logic [7:0] cd);
        return {w, dw, bl, rq, ab, ft, cd};
    endfunction

    function automatic logic [13:0] obs();
        return {walk, dont_walk, blink, req_pending, abort, fault, countdown};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn   = 1'b0;
        light = LIGHT_RED;
        tick();
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        do_reset();
        exp = pack(0, 1, 1, 0, 0, 0, 8'd0);
        total_cnt++;
        if (obs() !== exp) $display("FAIL reset_state got=%b exp=%b", obs(), exp);
        else pass_cnt++;
    endtask

    // Button at cycle 3, green 10..19, red from 20: WALK 21..32, FLASH 33..38.
    task automatic test_walk_flash();
        logic [13:0] exp;
        logic [5:0]  pat;
        logic        w, fl, bl, rq;
        logic [7:0]  cd;
        pat = 6'b110011;
        do_reset();
        for (int c = 0; c < 46; c++) begin
            btn   = (c == 3);
            light = ((c >= 10 && c < 20) || c >= 41) ? LIGHT_GREEN : LIGHT_RED;
            w  = (c >= 21 && c <= 32);
            fl = (c >= 33 && c <= 38);
            rq = (c >= 4 && c <= 20);
            cd = w ? 8'(32 - c) : (fl ? 8'(38 - c) : 8'd0);
            bl = fl ? pat[c - 33] : 1'b1;
            exp = pack(w, !w, bl, rq, 0, 0, cd);
            total_cnt++;
            if (obs() !== exp) $display("FAIL walk_flash cycle=%0d got=%b exp=%b", c, obs(), exp);
            else pass_cnt++;
            tick();
        end
        btn = 1'b0;
    endtask

    // Red entries without any request never grant WALK; a mid-red request waits.
    task automatic test_no_btn();
        logic [13:0] exp;
        int          m;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            m = c % 10;
            light = (m < 4) ? LIGHT_RED : (m < 7) ? LIGHT_GREEN : (m < 9) ? LIGHT_YELLOW : LIGHT_RED;
            tick();
            exp = pack(0, 1, 1, 0, 0, 0, 8'd0);
            total_cnt++;
            if (obs() !== exp) $display("FAIL no_btn cycle=%0d got=%b exp=%b", c, obs(), exp);
            else pass_cnt++;
        end
        light = LIGHT_RED;
        tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = pack(0, 1, 1, 1, 0, 0, 8'd0);
            total_cnt++;
            if (obs() !== exp) $display("FAIL mid_red_wait step=%0d got=%b exp=%b", i, obs(), exp);
            else pass_cnt++;
            tick();
        end
    endtask

    // Button rise coincident with red entry is served; a rise during WALK is dropped.
    task automatic test_back_to_back();
        logic [13:0] exp;
        do_reset();
        light = LIGHT_GREEN;
        tick(); tick(); tick();
        light = LIGHT_RED;
        btn   = 1'b1;
        tick();
        exp = pack(1, 0, 1, 0, 0, 0, 8'd11);
        total_cnt++;
        if (obs() !== exp) $display("FAIL simul_rise_entry got=%b exp=%b", obs(), exp);
        else pass_cnt++;
        btn = 1'b0;
        tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        exp = pack(1, 0, 1, 0, 0, 0, 8'd9);
        total_cnt++;
        if (obs() !== exp) $display("FAIL btn_in_walk got=%b exp=%b", obs(), exp);
        else pass_cnt++;
    endtask

    // Green five cycles into WALK aborts, re-arms the request, and WALK returns at next red.
    task automatic test_abort();
        logic [13:0] exp;
        do_reset();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        light = LIGHT_GREEN;
        tick(); tick();
        light = LIGHT_RED;
        tick();
        tick(); tick(); tick(); tick();
        exp = pack(1, 0, 1, 0, 0, 0, 8'd7);
        total_cnt++;
        if (obs() !== exp) $display("FAIL abort_pre got=%b exp=%b", obs(), exp);
        else pass_cnt++;
        light = LIGHT_GREEN;
        tick();
        exp = pack(0, 1, 1, 1, 1, 0, 8'd0);
        total_cnt++;
        if (obs() !== exp) $display("FAIL abort_pulse got=%b exp=%b", obs(), exp);
        else pass_cnt++;
        tick();
        exp = pack(0, 1, 1, 1, 0, 0, 8'd0);
        total_cnt++;
        if (obs() !== exp) $display("FAIL abort_one_cycle got=%b exp=%b", obs(), exp);
        else pass_cnt++;
        light = LIGHT_RED;
        tick();
        exp = pack(1, 0, 1, 0, 0, 0, 8'd11);
        total_cnt++;
        if (obs() !== exp) $display("FAIL abort_regrant got=%b exp=%b", obs(), exp);
        else pass_cnt++;
    endtask

    // Illegal lamp codes force a sticky FAULT that only reset clears; request is held.
    task automatic test_fault();
        logic [13:0] exp;
        do_reset();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        light = LIGHT_GREEN;
        tick();
        light = LIGHT_RED;
        tick();
        light = 3'b110;
        tick();
        exp = pack(0, 1, 1, 0, 0, 1, 8'd0);
        total_cnt++;
        if (obs() !== exp) $display("FAIL fault_from_walk got=%b exp=%b", obs(), exp);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            light = i[0] ? LIGHT_RED : LIGHT_GREEN;
            btn   = (i == 2);
            tick();
            total_cnt++;
            if (obs() !== exp) $display("FAIL fault_sticky step=%0d got=%b exp=%b", i, obs(), exp);
            else pass_cnt++;
        end
        btn = 1'b0;
        do_reset();
        exp = pack(0, 1, 1, 0, 0, 0, 8'd0);
        total_cnt++;
        if (obs() !== exp) $display("FAIL fault_rst_clear got=%b exp=%b", obs(), exp);
        else pass_cnt++;
        btn = 1'b1;
        tick();
        btn = 1'b0;
        light = 3'b111;
        tick();
        exp = pack(0, 1, 1, 1, 0, 1, 8'd0);
        total_cnt++;
        if (obs() !== exp) $display("FAIL fault_req_held got=%b exp=%b", obs(), exp);
        else pass_cnt++;
    endtask

    initial begin
        rst   = 1'b1;
        btn   = 1'b0;
        light = LIGHT_RED;
        test_reset();
        test_walk_flash();
        test_no_btn();
        test_back_to_back();
        test_abort();
        test_fault();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
